// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared definitions for the ALU command controller.
// Holds the FSM encoding, the command header nibble and the ALU function codes.
// Included by every file of the block through a package import.
package alu_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_ALU_REQ  = 3'd3,
        ST_ALU_WAIT = 3'd4,
        ST_TX_LO    = 3'd5,
        ST_TX_HI    = 3'd6
    } state_t;

    // Upper nibble that marks a command header byte
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    // ALU function codes carried in the low nibble of the header
    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;
    localparam logic [3:0] FUN_MUL = 4'd2;
    localparam logic [3:0] FUN_DIV = 4'd3;

    function automatic logic is_header(input logic [7:0] b);
        return (b[7:4] == HDR_NIBBLE);
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of rx command, ALU and tx result signals around the controller.
// Pure wiring, no latency.
// tx side uses valid/ready; rx and ALU sides are strobes with no backpressure.
interface alu_cmd_ctrl_if #(
    parameter int OPER_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [OPER_WIDTH-1:0]   alu_a;
    logic [OPER_WIDTH-1:0]   alu_b;
    logic [FUN_WIDTH-1:0]    alu_fun;
    logic                    alu_en;
    logic [2*OPER_WIDTH-1:0] alu_out;
    logic                    alu_valid;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    err;

    // Controller side
    modport master (
        input  rx_data, rx_valid, alu_out, alu_valid, tx_ready,
        output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
    );

    // Environment side: receiver, ALU and transmitter
    modport slave (
        output rx_data, rx_valid, alu_out, alu_valid, tx_ready,
        input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Collects header/A/B bytes, fires the ALU once, returns the 16-bit result as two bytes.
// Latency: alu_en one cycle after the B byte; first tx byte one cycle after alu_valid.
// tx bytes held while tx_ready is low; rx bytes arriving while not collecting are dropped with err.
module alu_cmd_ctrl #(
    parameter int OPER_WIDTH = 8,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            async_rst,
    alu_cmd_ctrl_if.master  bus
);
    import alu_cmd_ctrl_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RES_W = 2 * OPER_WIDTH;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [RES_W-1:0]   result;
    logic               err_nxt;
    logic               ld_fun;
    logic               ld_a;
    logic               ld_b;
    logic               ld_res;
    logic               tx_hs;

    assign tx_hs = bus.tx_valid & bus.tx_ready;

    // Next-state decode; any rx byte outside the collecting states is an overrun
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        ld_fun    = 1'b0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_res    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (is_header(bus.rx_data)) begin
                        ld_fun    = 1'b1;
                        state_nxt = ST_GET_A;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (bus.rx_valid) begin
                    ld_a      = 1'b1;
                    state_nxt = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (bus.rx_valid) begin
                    ld_b      = 1'b1;
                    state_nxt = ST_ALU_REQ;
                end
            end
            ST_ALU_REQ: begin
                err_nxt   = bus.rx_valid;
                state_nxt = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                err_nxt = bus.rx_valid;
                if (bus.alu_valid) begin
                    ld_res    = 1'b1;
                    state_nxt = ST_TX_LO;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                err_nxt = bus.rx_valid;
                if (tx_hs) state_nxt = ST_TX_HI;
            end
            ST_TX_HI: begin
                // A header landing on the final handshake is still an overrun
                err_nxt = bus.rx_valid;
                if (tx_hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered status pulses
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state      <= ST_IDLE;
            bus.alu_en <= 1'b0;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus.alu_en <= (state_nxt == ST_ALU_REQ);
            bus.busy   <= (state_nxt != ST_IDLE);
            bus.err    <= err_nxt;
        end
    end

    // Operand, function and result capture; values hold until overwritten by the next frame
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            bus.alu_fun <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            result      <= '0;
        end else begin
            if (ld_fun) bus.alu_fun <= bus.rx_data[FUN_WIDTH-1:0];
            if (ld_a)   bus.alu_a   <= OPER_WIDTH'(bus.rx_data);
            if (ld_b)   bus.alu_b   <= OPER_WIDTH'(bus.rx_data);
            if (ld_res) result      <= bus.alu_out;
        end
    end

    // Timeout counter runs only in ALU_WAIT and is zero on entry
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ALU_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // tx byte decoded straight from state so it stays stable under backpressure
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        case (state)
            ST_TX_LO: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = result[7:0];
            end
            ST_TX_HI: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = result[15:8];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter OPER_WIDTH, default 8, ALU operand width.
REQ-002 SHALL have parameter FUN_WIDTH, default 4, ALU function-select width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waited for alu_valid.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port async_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data  input  8  received command byte.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have port alu_a  output  OPER_WIDTH  operand A to ALU.
REQ-009 SHALL have port alu_b  output  OPER_WIDTH  operand B to ALU.
REQ-010 SHALL have port alu_fun  output  FUN_WIDTH  ALU function select.
REQ-011 SHALL have port alu_en  output  1  ALU enable, one-cycle pulse.
REQ-012 SHALL have port alu_out  input  2*OPER_WIDTH  ALU result.
REQ-013 SHALL have port alu_valid  input  1  ALU result valid.
REQ-014 SHALL have port tx_data  output  8  result byte to transmitter.
REQ-015 SHALL have port tx_valid  output  1  tx_data valid.
REQ-016 SHALL have port tx_ready  input  1  transmitter accepts byte.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-019 SHALL implement FSM states IDLE, GET_A, GET_B, ALU_REQ, ALU_WAIT, TX_LO, TX_HI.
REQ-020 SHALL, in IDLE on rx_valid with rx_data[7:4]=4'hA, latch alu_fun=rx_data[FUN_WIDTH-1:0] and go to GET_A.
REQ-021 SHALL, in IDLE on rx_valid with rx_data[7:4]!=4'hA, pulse err for one cycle and remain in IDLE.
REQ-022 SHALL, in GET_A on rx_valid, latch alu_a=rx_data and go to GET_B; GET_B likewise latches alu_b and goes to ALU_REQ.
REQ-023 SHALL assert alu_en for exactly the one ALU_REQ cycle, then enter ALU_WAIT with timeout counter cleared.
REQ-024 SHALL hold alu_a, alu_b, alu_fun stable from latch until return to IDLE.
REQ-025 SHALL, in ALU_WAIT, capture alu_out into a result register on the first cycle alu_valid=1 and go to TX_LO.
REQ-026 SHALL, if alu_valid is still low after TIMEOUT cycles in ALU_WAIT, pulse err and return to IDLE without transmitting.
REQ-027 SHALL, in TX_LO, drive tx_data=result[7:0], tx_valid=1; on tx_valid&tx_ready go to TX_HI.
REQ-028 SHALL, in TX_HI, drive tx_data=result[15:8], tx_valid=1; on tx_valid&tx_ready go to IDLE.
REQ-029 SHALL hold tx_data and tx_valid unchanged while tx_valid=1 and tx_ready=0; tx_valid=0 outside TX_LO/TX_HI.
REQ-030 SHALL drop rx_valid bytes arriving in ALU_REQ, ALU_WAIT, TX_LO, TX_HI and pulse err (overrun) for each.
REQ-031 SHALL make a header byte accepted in the same cycle the TX_HI handshake completes impossible: that byte is dropped with err.
REQ-032 SHALL register all outputs except tx_data/tx_valid, which decode from state and result register.

Reset
REQ-033 SHALL, on async_rst low, immediately force state=IDLE, alu_a=0, alu_b=0, alu_fun=0, alu_en=0, tx_valid=0, tx_data=0, busy=0, err=0, result=0, counter=0.
REQ-034 SHALL abort any frame in progress on reset; no partial transmission resumes after release.

Structure
REQ-035 SHALL take state encoding, header nibble 4'hA and FUN codes (ADD=0, SUB=1, MUL=2, DIV=3) from the shared system package.
REQ-036 SHALL be a single module; no sub-module is required.

Verification
REQ-037 SHALL verify: rx 0xA0,0x12,0x34; alu_out=0x0046 one cycle after alu_en -> alu_fun=0, alu_a=0x12, alu_b=0x34, tx 0x46 then 0x00, busy low after.
REQ-038 SHALL verify: rx 0x55 in IDLE -> err one-cycle pulse, busy stays 0, no alu_en.
REQ-039 SHALL verify: frame 0xA2,0x10,0x10, result 0x0100, tx_ready low 5 cycles -> tx_data held 0x00 with tx_valid=1, then 0x01.
REQ-040 SHALL verify: alu_valid never asserted -> err pulse exactly TIMEOUT cycles after entering ALU_WAIT, return to IDLE, tx_valid never high.
REQ-041 SHALL verify: rx_valid during ALU_WAIT -> err pulse, byte ignored, transmitted result unchanged.
REQ-042 SHALL verify: async_rst low during TX_HI -> all outputs zero immediately; next frame 0xA1,0x05,0x03 with result 0x0002 -> tx 0x02, 0x00.
